output_port_arbiter: RTL

- Shares one router output port among five input ports (0=Local, 1=North, 2=East, 3=South, 4=West).
- Uses round-robin arbitration with wormhole packet locking.
- Sits between the five input buffers and the output channel's write/full interface.
- A zero flit means "no data". When granted, the block pops one flit from the winning input buffer per cycle. It drives a registered write/data pair downstream and honours downstream back-pressure (full).

---
 rtl/output_port_arbiter_pkg.sv | 29 ++
 rtl/output_port_arbiter_rr_arbiter.sv | 38 +++
 rtl/output_port_arbiter.sv | 111 +++++++++++
 3 files changed

// File: rtl/output_port_arbiter_pkg.sv
// Shared constants for the router output-port arbiter.
// Flit type codes, port indices and small index helpers.
package output_port_arbiter_pkg;

    localparam int NUM_PORTS = 5;
    localparam int FLIT_W    = 8;

    localparam logic [1:0] FLIT_SINGLE = 2'b00;
    localparam logic [1:0] FLIT_HEAD   = 2'b01;
    localparam logic [1:0] FLIT_BODY   = 2'b10;
    localparam logic [1:0] FLIT_TAIL   = 2'b11;

    localparam logic [2:0] PORT_LOCAL = 3'd0;
    localparam logic [2:0] PORT_NORTH = 3'd1;
    localparam logic [2:0] PORT_EAST  = 3'd2;
    localparam logic [2:0] PORT_SOUTH = 3'd3;
    localparam logic [2:0] PORT_WEST  = 3'd4;

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } arb_state_t;

    // Successor of a port index, wrapping West back to Local.
    function automatic logic [2:0] next_idx(input logic [2:0] i);
        return (i >= PORT_WEST) ? PORT_LOCAL : i + 3'd1;
    endfunction

endpackage

// File: rtl/output_port_arbiter_rr_arbiter.sv
// Combinational five-way round-robin selector.
// Picks the first requester at or after ptr, searching cyclically.
import output_port_arbiter_pkg::*;

module rr_arbiter (
    input  logic [4:0] req,
    input  logic [2:0] ptr,
    output logic [4:0] grant,
    output logic [2:0] grant_idx,
    output logic       any_grant
);

    logic [3:0] sum;
    logic [2:0] idx;

    // Walk ptr, ptr+1, ... mod 5 and latch the first hit.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            sum = {1'b0, ptr} + 4'(k);
            if (sum >= 4'd10)
                sum = sum - 4'd10;
            else if (sum >= 4'd5)
                sum = sum - 4'd5;
            idx = sum[2:0];
            if (!any_grant && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                any_grant  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/output_port_arbiter.sv
// Router output-port arbiter: round-robin between five inputs
// with wormhole locking from HEAD until TAIL.
import output_port_arbiter_pkg::*;

module output_port_arbiter #(
    parameter int DATA_WIDTH = FLIT_W,
    parameter int NUM_IN     = NUM_PORTS
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
    output logic [NUM_IN-1:0]            in_ack,
    input  logic                         full,
    output logic                         write,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic                         busy,
    output logic [2:0]                   owner
);

    arb_state_t state;
    logic [2:0] rr_ptr;

    logic [NUM_IN-1:0]     req;
    logic [4:0]            rr_grant;
    logic [2:0]            rr_idx;
    logic                  rr_any;
    logic [2:0]            sel;
    logic                  sel_valid;
    logic                  xfer;
    logic [DATA_WIDTH-1:0] sel_flit;
    logic [1:0]            sel_type;

    // A nonzero head-of-buffer flit is a request.
    always_comb begin
        req = '0;
        for (int i = 0; i < NUM_IN; i++)
            req[i] = |in_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_arbiter u_rr (
        .req       (req),
        .ptr       (rr_ptr),
        .grant     (rr_grant),
        .grant_idx (rr_idx),
        .any_grant (rr_any)
    );

    // Locked packets bypass the round-robin and stick to the owner.
    always_comb begin
        sel       = rr_idx;
        sel_valid = rr_any;
        if (state == ST_LOCKED) begin
            sel       = owner;
            sel_valid = 1'b0;
            for (int i = 0; i < NUM_IN; i++)
                if (owner == 3'(i))
                    sel_valid = req[i];
        end
    end

    // Pop strobe and selected flit; nothing moves in reset or when full.
    always_comb begin
        xfer     = !rst && !full && sel_valid;
        in_ack   = '0;
        sel_flit = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (sel == 3'(i)) begin
                in_ack[i] = xfer;
                sel_flit  = in_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        sel_type = sel_flit[DATA_WIDTH-1 -: 2];
    end

    // Lock FSM, round-robin pointer and registered output stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            rr_ptr   <= PORT_LOCAL;
            owner    <= PORT_LOCAL;
            busy     <= 1'b0;
            write    <= 1'b0;
            data_out <= '0;
        end else begin
            write    <= xfer;
            data_out <= xfer ? sel_flit : '0;
            if (xfer) begin
                case (state)
                    ST_IDLE: begin
                        rr_ptr <= next_idx(sel);
                        if (sel_type == FLIT_HEAD) begin
                            owner <= sel;
                            busy  <= 1'b1;
                            state <= ST_LOCKED;
                        end
                    end
                    ST_LOCKED: begin
                        if (sel_type == FLIT_TAIL) begin
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    wire unused_grant = ^rr_grant;

endmodule
